// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer that breaks one ALU opcode into single-word micro-steps.
// Word and pass ordering come from the opcode, and the carry chain is threaded between steps.
module alu_op_sequencer #(
    parameter int MAX_WORDS = 4,
    parameter int WC_W      = 3,
    parameter int SHAMT_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [5:0]         op_code,
    input  logic [WC_W-1:0]    op_words,
    input  logic [SHAMT_W-1:0] op_shamt,
    input  logic               c_flag,
    output logic               step_valid,
    input  logic               step_ready,
    output logic [5:0]         step_ctrl,
    output logic               step_cin,
    output logic [WC_W-1:0]    step_word,
    output logic               step_last,
    input  logic               alu_cout,
    output logic               done,
    output logic               done_carry,
    output logic               err
);

    localparam logic [5:0] OP_ADD = 6'b010010, OP_SUB = 6'b010001,
                           OP_INC = 6'b011011, OP_DEC = 6'b011000;
    localparam logic [5:0] OP_OR  = 6'b001010, OP_NOT = 6'b001100,
                           OP_XOR = 6'b001110, OP_AND = 6'b000110, OP_MOV = 6'b000000;
    localparam logic [5:0] OP_SLA = 6'b100100, OP_SLL = 6'b100000, OP_ROL = 6'b100010,
                           OP_SRA = 6'b101100, OP_SRL = 6'b101000, OP_ROR = 6'b101010;
    localparam logic [WC_W-1:0] MAXW = WC_W'(MAX_WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_reg, state_next;
    logic [5:0]           code_reg, code_next;
    logic [WC_W-1:0]      n_reg, n_next;
    logic [WC_W-1:0]      cnt_reg, cnt_next;
    logic [WC_W-1:0]      word_reg, word_next;
    logic [SHAMT_W-1:0]   p_reg, p_next;
    logic [SHAMT_W-1:0]   pass_reg, pass_next;
    logic                 cy_reg, cy_next;
    logic                 err_reg, err_next;

    logic [WC_W-1:0]      n_clamp;
    logic                 last_word, last_pass;
    logic                 first_cin;

    function automatic logic is_legal(input logic [5:0] c);
        case (c)
            OP_ADD, OP_SUB, OP_INC, OP_DEC,
            OP_OR, OP_NOT, OP_XOR, OP_AND, OP_MOV,
            OP_SLA, OP_SLL, OP_ROL, OP_SRA, OP_SRL, OP_ROR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_shift(input logic [5:0] c);
        case (c)
            OP_SLA, OP_SLL, OP_ROL, OP_SRA, OP_SRL, OP_ROR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_right(input logic [5:0] c);
        return (c == OP_SRA) || (c == OP_SRL) || (c == OP_ROR);
    endfunction

    function automatic logic is_logic(input logic [5:0] c);
        case (c)
            OP_OR, OP_NOT, OP_XOR, OP_AND, OP_MOV: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            code_reg  <= '0;
            n_reg     <= WC_W'(1);
            cnt_reg   <= '0;
            word_reg  <= '0;
            p_reg     <= SHAMT_W'(1);
            pass_reg  <= '0;
            cy_reg    <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            code_reg  <= code_next;
            n_reg     <= n_next;
            cnt_reg   <= cnt_next;
            word_reg  <= word_next;
            p_reg     <= p_next;
            pass_reg  <= pass_next;
            cy_reg    <= cy_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        if (op_words == '0)
            n_clamp = WC_W'(1);
        else if (op_words > MAXW)
            n_clamp = MAXW;
        else
            n_clamp = op_words;
    end

    assign last_word = (cnt_reg == n_reg - WC_W'(1));
    assign last_pass = (pass_reg == p_reg - SHAMT_W'(1));

    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        n_next     = n_reg;
        cnt_next   = cnt_reg;
        word_next  = word_reg;
        p_next     = p_reg;
        pass_next  = pass_reg;
        cy_next    = cy_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (op_valid) begin
                    code_next = op_code;
                    n_next    = n_clamp;
                    cnt_next  = '0;
                    pass_next = '0;
                    cy_next   = c_flag;
                    word_next = is_right(op_code) ? n_clamp - WC_W'(1) : '0;
                    if (is_shift(op_code) && op_shamt != '0)
                        p_next = op_shamt;
                    else
                        p_next = SHAMT_W'(1);
                    if (is_legal(op_code)) begin
                        state_next = RUN;
                        err_next   = 1'b0;
                    end else begin
                        state_next = DONE;
                        err_next   = 1'b1;
                    end
                end
            end
            RUN: begin
                if (step_ready) begin
                    cy_next = alu_cout;
                    if (last_word) begin
                        // Each pass restarts at its own first word index.
                        cnt_next  = '0;
                        word_next = is_right(code_reg) ? n_reg - WC_W'(1) : '0;
                        if (last_pass)
                            state_next = DONE;
                        else
                            pass_next = pass_reg + SHAMT_W'(1);
                    end else begin
                        cnt_next  = cnt_reg + WC_W'(1);
                        word_next = is_right(code_reg) ? word_reg - WC_W'(1)
                                                       : word_reg + WC_W'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Carry-in seed for the first word of an operation or of a shift pass.
    always_comb begin
        case (code_reg)
            OP_SUB, OP_INC: first_cin = 1'b1;
            OP_ROL, OP_ROR: first_cin = cy_reg;
            default:        first_cin = 1'b0;
        endcase
    end

    always_comb begin
        op_ready   = (state_reg == IDLE);
        step_valid = (state_reg == RUN);
        done       = (state_reg == DONE);
        err        = (state_reg == DONE) && err_reg;
        done_carry = (state_reg == DONE) && cy_reg;
        step_ctrl  = code_reg;
        step_word  = word_reg;
        step_last  = (state_reg == RUN) && last_word && last_pass;
        step_cin   = 1'b0;
        if (state_reg == RUN) begin
            if (cnt_reg == '0)
                step_cin = first_cin;
            else if (!is_logic(code_reg))
                step_cin = cy_reg;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised and directed bench for alu_op_sequencer against a step-list reference model.
// Every micro-step's ctrl/word/cin/last is predicted from the opcode rules and compared each cycle.
module tb_alu_op_sequencer;

    localparam logic [5:0] OP_ADD = 6'b010010, OP_SUB = 6'b010001,
                           OP_INC = 6'b011011, OP_DEC = 6'b011000;
    localparam logic [5:0] OP_OR  = 6'b001010, OP_NOT = 6'b001100,
                           OP_XOR = 6'b001110, OP_AND = 6'b000110, OP_MOV = 6'b000000;
    localparam logic [5:0] OP_SLA = 6'b100100, OP_SLL = 6'b100000, OP_ROL = 6'b100010,
                           OP_SRA = 6'b101100, OP_SRL = 6'b101000, OP_ROR = 6'b101010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [5:0] op_code;
    logic [2:0] op_words;
    logic [3:0] op_shamt;
    logic       c_flag;
    logic       step_valid;
    logic       step_ready;
    logic [5:0] step_ctrl;
    logic       step_cin;
    logic [2:0] step_word;
    logic       step_last;
    logic       alu_cout;
    logic       done;
    logic       done_carry;
    logic       err;

    int checks = 0;
    int errors = 0;

    logic [5:0] legal_codes [15] = '{OP_ADD, OP_SUB, OP_INC, OP_DEC,
                                    OP_OR, OP_NOT, OP_XOR, OP_AND, OP_MOV,
                                    OP_SLA, OP_SLL, OP_ROL, OP_SRA, OP_SRL, OP_ROR};

    alu_op_sequencer #(.MAX_WORDS(4), .WC_W(3), .SHAMT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_words(op_words), .op_shamt(op_shamt), .c_flag(c_flag),
        .step_valid(step_valid), .step_ready(step_ready), .step_ctrl(step_ctrl),
        .step_cin(step_cin), .step_word(step_word), .step_last(step_last),
        .alu_cout(alu_cout), .done(done), .done_carry(done_carry), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_list(input logic [5:0] c);
        foreach (legal_codes[i]) if (legal_codes[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: enumerate the expected steps of one op and follow the carry chain.
    task automatic run_op(input logic [5:0] code, input int words, input int shamt,
                          input logic cflag, input bit full_ready,
                          input bit use_pat, input logic [15:0] cpat);
        int   n, p, si, wait_cyc, w;
        bit   legal, shift, right, logicop, hs, lst;
        logic cy, exp_cin;
        legal   = in_list(code);
        shift   = legal && (code inside {OP_SLA, OP_SLL, OP_ROL, OP_SRA, OP_SRL, OP_ROR});
        right   = code inside {OP_SRA, OP_SRL, OP_ROR};
        logicop = code inside {OP_OR, OP_NOT, OP_XOR, OP_AND, OP_MOV};
        n = (words == 0) ? 1 : ((words > 4) ? 4 : words);
        p = shift ? ((shamt == 0) ? 1 : shamt) : 1;

        op_valid = 1'b1; op_code = code; op_words = 3'(words);
        op_shamt = 4'(shamt); c_flag = cflag;
        chk("op_ready_idle", 32'(op_ready), 32'd1);
        @(posedge clk); #1;
        op_valid = 1'b0; op_code = 6'($urandom); c_flag = 1'($urandom);
        cy = cflag;
        si = 0;
        if (!legal) begin
            chk("err_step_valid", 32'(step_valid), 32'd0);
            chk("err_done", 32'(done), 32'd1);
            chk("err_err", 32'(err), 32'd1);
            chk("err_done_carry", 32'(done_carry), 32'(cflag));
        end else begin
            for (int ps = 0; ps < p; ps++) begin
                for (int k = 0; k < n; k++) begin
                    w = right ? (n - 1 - k) : k;
                    if (k == 0)
                        exp_cin = (code inside {OP_SUB, OP_INC}) ? 1'b1 :
                                  (code inside {OP_ROL, OP_ROR}) ? cy : 1'b0;
                    else
                        exp_cin = logicop ? 1'b0 : cy;
                    lst = (ps == p - 1) && (k == n - 1);
                    hs = 1'b0;
                    wait_cyc = 0;
                    while (!hs) begin
                        chk("step_valid", 32'(step_valid), 32'd1);
                        chk("step_ctrl", 32'(step_ctrl), 32'(code));
                        chk("step_word", 32'(step_word), 32'(w));
                        chk("step_cin", 32'(step_cin), 32'(exp_cin));
                        chk("step_last", 32'(step_last), 32'(lst));
                        chk("run_done", 32'(done), 32'd0);
                        chk("run_op_ready", 32'(op_ready), 32'd0);
                        step_ready = (full_ready || wait_cyc > 6) ? 1'b1 : 1'($urandom);
                        alu_cout   = use_pat ? cpat[si] : 1'($urandom);
                        op_valid   = 1'($urandom);
                        @(posedge clk); #1;
                        if (step_ready) begin
                            hs = 1'b1;
                            cy = alu_cout;
                        end
                        wait_cyc++;
                    end
                    si++;
                end
            end
            op_valid = 1'b0;
            chk("done", 32'(done), 32'd1);
            chk("done_carry", 32'(done_carry), 32'(cy));
            chk("done_err", 32'(err), 32'd0);
            chk("done_step_valid", 32'(step_valid), 32'd0);
            chk("done_op_ready", 32'(op_ready), 32'd0);
        end
        step_ready = 1'b0;
        @(posedge clk); #1;
        chk("after_done", 32'(done), 32'd0);
        chk("after_op_ready", 32'(op_ready), 32'd1);
        $display("op code=%b words=%0d shamt=%0d cflag=%0d steps=%0d carry=%0d legal=%0d",
                 code, words, shamt, cflag, si, cy, legal);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_op_ready"}, 32'(op_ready), 32'd1);
        chk({tag, "_step_valid"}, 32'(step_valid), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_done_carry"}, 32'(done_carry), 32'd0);
        chk({tag, "_step_cin"}, 32'(step_cin), 32'd0);
        chk({tag, "_step_last"}, 32'(step_last), 32'd0);
        chk({tag, "_step_ctrl"}, 32'(step_ctrl), 32'd0);
        chk({tag, "_step_word"}, 32'(step_word), 32'd0);
    endtask

    initial begin
        logic [5:0] rc;
        rst_n = 1'b0; op_valid = 1'b0; op_code = '0; op_words = '0; op_shamt = '0;
        c_flag = 1'b0; step_ready = 1'b0; alu_cout = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(OP_ADD, 2, 0, 1'b1, 1'b1, 1'b1, 16'hFFFF);
        run_op(OP_SUB, 1, 0, 1'b0, 1'b1, 1'b1, 16'h0000);
        run_op(OP_SRL, 3, 2, 1'b0, 1'b1, 1'b1, 16'b101101);
        run_op(OP_ROL, 1, 3, 1'b1, 1'b1, 1'b1, 16'b010);
        run_op(6'b111111, 2, 0, 1'b1, 1'b1, 1'b0, 16'h0);
        run_op(OP_XOR, 7, 5, 1'b1, 1'b1, 1'b1, 16'hFFFF);
        run_op(OP_ROR, 0, 0, 1'b1, 1'b0, 1'b0, 16'h0);

        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 9) < 9)
                rc = legal_codes[$urandom_range(0, 14)];
            else
                rc = 6'($urandom);
            run_op(rc, $urandom_range(0, 7), $urandom_range(0, 15), 1'($urandom),
                   1'($urandom), 1'b0, 16'h0);
        end

        // Stall mid-op, then drop reset while RUN is active.
        op_valid = 1'b1; op_code = OP_SRL; op_words = 3'd3; op_shamt = 4'd2; c_flag = 1'b0;
        @(posedge clk); #1;
        op_valid = 1'b0;
        step_ready = 1'b1; alu_cout = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step_ready = 1'b0; alu_cout = 1'b0;
        for (int s = 0; s < 5; s++) begin
            chk("stall_valid", 32'(step_valid), 32'd1);
            chk("stall_word", 32'(step_word), 32'd0);
            chk("stall_cin", 32'(step_cin), 32'd1);
            chk("stall_last", 32'(step_last), 32'd0);
            alu_cout = 1'($urandom);
            @(posedge clk); #1;
        end
        $display("op code=%b stalled 5 cycles at word 0", OP_SRL);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            chk("rst_no_done", 32'(done), 32'd0);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(op_ready), 32'd1);
        chk("post_rst_done", 32'(done), 32'd0);
        run_op(OP_INC, 4, 0, 1'b0, 1'b1, 1'b0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
